pingpong_bank_ctrl: RTL and testbench

Sequencing controller for the mapper→FFT ping-pong buffer. It accepts per-symbol configuration from the mapper, steers mapper samples into whichever bank is free, and drains full banks toward the FFT in strict symbol order. It generates write/read addresses, bank selects, FFT framing and mapper backpressure, and reports protocol errors. It sits between the modulation mapper, the two 1200-deep bank memories and the DFT-precoding FFT, all on one clock domain.

---
 rtl/pingpong_bank_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_pingpong_bank_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_bank_ctrl.sv
// Ping-pong bank sequencer between the modulation mapper and the FFT.
// Fills whichever bank is free and drains full banks in arrival order.
module pingpong_bank_ctrl #(
    parameter int MEM_DEPTH  = 1200,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  sym_start,
    input  logic [ADDR_WIDTH-1:0] sym_len,
    input  logic                  mod_valid,
    output logic                  mod_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  wr_bank,
    input  logic                  fft_ready,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_bank,
    output logic                  fft_start,
    output logic                  fft_valid,
    output logic                  fft_last,
    output logic [1:0]            bank_full,
    output logic                  cfg_err,
    output logic                  ovf_err
);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_FILL = 2'd2} w_state_t;
    typedef enum logic       {R_IDLE = 1'b0, R_READ = 1'b1} r_state_t;
    typedef enum logic [1:0] {B_EMPTY = 2'd0, B_FILLING = 2'd1, B_FULL = 2'd2, B_DRAINING = 2'd3} bank_t;

    localparam logic [ADDR_WIDTH-1:0] DEPTH_L = ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ZERO_L  = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ONE_L   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    w_state_t              w_state_q, w_state_d;
    r_state_t              r_state_q, r_state_d;
    bank_t                 bank_q [2];
    bank_t                 bank_d [2];
    logic [ADDR_WIDTH-1:0] len_q  [2];
    logic [ADDR_WIDTH-1:0] len_d  [2];
    logic [ADDR_WIDTH-1:0] pend_len_q, pend_len_d;
    logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
    logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic                  wr_sel_q, wr_sel_d;
    logic                  rd_sel_q, rd_sel_d;
    logic                  fft_valid_q, fft_last_q;
    logic                  cfg_err_q, cfg_err_d;
    logic                  ovf_err_q;
    logic                  len_legal_s, wr_last_s, rd_last_s;

    assign len_legal_s = (sym_len != ZERO_L) && (sym_len <= DEPTH_L);
    assign mod_ready   = (w_state_q == W_FILL);
    assign wr_en       = mod_valid & mod_ready;
    assign wr_addr     = mod_ready ? wr_cnt_q : ZERO_L;
    assign wr_bank     = mod_ready & wr_sel_q;
    assign wr_last_s   = (wr_cnt_q == (len_q[wr_sel_q] - ONE_L));
    assign rd_en       = (r_state_q == R_READ);
    assign rd_addr     = rd_en ? rd_cnt_q : ZERO_L;
    assign rd_bank     = rd_en & rd_sel_q;
    assign rd_last_s   = (rd_cnt_q == (len_q[rd_sel_q] - ONE_L));
    assign fft_start   = rd_en & (rd_cnt_q == ZERO_L);
    assign fft_valid   = fft_valid_q;
    assign fft_last    = fft_last_q;
    assign cfg_err     = cfg_err_q;
    assign ovf_err     = ovf_err_q;
    assign bank_full[0] = (bank_q[0] == B_FULL) || (bank_q[0] == B_DRAINING);
    assign bank_full[1] = (bank_q[1] == B_FULL) || (bank_q[1] == B_DRAINING);

    // Next-state logic for both FSMs and the per-bank lifecycle
    always_comb begin
        w_state_d  = w_state_q;
        r_state_d  = r_state_q;
        bank_d     = bank_q;
        len_d      = len_q;
        pend_len_d = pend_len_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        wr_sel_d   = wr_sel_q;
        rd_sel_d   = rd_sel_q;
        cfg_err_d  = 1'b0;

        case (w_state_q)
            W_IDLE: begin
                if (sym_start && len_legal_s) begin
                    pend_len_d = sym_len;
                    if (bank_q[wr_sel_q] == B_EMPTY) begin
                        w_state_d        = W_FILL;
                        bank_d[wr_sel_q] = B_FILLING;
                        len_d[wr_sel_q]  = sym_len;
                    end else begin
                        w_state_d = W_WAIT;
                    end
                end else begin
                    cfg_err_d = sym_start;
                end
            end
            W_WAIT: begin
                cfg_err_d = sym_start;
                if (bank_q[wr_sel_q] == B_EMPTY) begin
                    w_state_d        = W_FILL;
                    bank_d[wr_sel_q] = B_FILLING;
                    len_d[wr_sel_q]  = pend_len_q;
                end else begin
                    w_state_d = W_WAIT;
                end
            end
            W_FILL: begin
                cfg_err_d = sym_start;
                if (wr_en && wr_last_s) begin
                    bank_d[wr_sel_q] = B_FULL;
                    wr_cnt_d         = ZERO_L;
                    wr_sel_d         = ~wr_sel_q;
                    w_state_d        = W_IDLE;
                end else if (wr_en) begin
                    wr_cnt_d = wr_cnt_q + ONE_L;
                end else begin
                    wr_cnt_d = wr_cnt_q;
                end
            end
            default: begin
                w_state_d = W_IDLE;
            end
        endcase

        // Read side only ever touches a FULL/DRAINING bank, never the one being filled
        case (r_state_q)
            R_IDLE: begin
                if ((bank_q[rd_sel_q] == B_FULL) && fft_ready) begin
                    r_state_d        = R_READ;
                    bank_d[rd_sel_q] = B_DRAINING;
                    rd_cnt_d         = ZERO_L;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_READ: begin
                if (rd_last_s) begin
                    bank_d[rd_sel_q] = B_EMPTY;
                    rd_cnt_d         = ZERO_L;
                    rd_sel_d         = ~rd_sel_q;
                    r_state_d        = R_IDLE;
                end else begin
                    rd_cnt_d = rd_cnt_q + ONE_L;
                end
            end
            default: begin
                r_state_d = R_IDLE;
            end
        endcase
    end

    // State, counters and registered status outputs
    always_ff @(posedge CLK) begin
        if (!RST) begin
            w_state_q   <= W_IDLE;
            r_state_q   <= R_IDLE;
            bank_q[0]   <= B_EMPTY;
            bank_q[1]   <= B_EMPTY;
            len_q[0]    <= ZERO_L;
            len_q[1]    <= ZERO_L;
            pend_len_q  <= ZERO_L;
            wr_cnt_q    <= ZERO_L;
            rd_cnt_q    <= ZERO_L;
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            fft_valid_q <= 1'b0;
            fft_last_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            ovf_err_q   <= 1'b0;
        end else begin
            w_state_q   <= w_state_d;
            r_state_q   <= r_state_d;
            bank_q      <= bank_d;
            len_q       <= len_d;
            pend_len_q  <= pend_len_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            fft_valid_q <= rd_en;
            fft_last_q  <= rd_en & rd_last_s;
            cfg_err_q   <= cfg_err_d;
            ovf_err_q   <= mod_valid & ~mod_ready;
        end
    end

endmodule

// File: tb/tb_pingpong_bank_ctrl.sv
// Directed bench for pingpong_bank_ctrl: write-side checks inline, read-side
// checked against a scoreboard of expected (bank, addr, start, last) entries.
module tb_pingpong_bank_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        sym_start = 1'b0;
    logic [10:0] sym_len = 11'd0;
    logic        mod_valid = 1'b0;
    logic        mod_ready;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic        wr_bank;
    logic        fft_ready = 1'b0;
    logic        rd_en;
    logic [10:0] rd_addr;
    logic        rd_bank;
    logic        fft_start;
    logic        fft_valid;
    logic        fft_last;
    logic [1:0]  bank_full;
    logic        cfg_err;
    logic        ovf_err;

    typedef struct packed {
        logic        bank;
        logic [10:0] addr;
        logic        start;
        logic        last;
    } rd_exp_t;

    rd_exp_t sb[$];
    int      n_tests = 0;
    int      n_fail  = 0;
    int      ovf_cnt = 0;
    bit      mon_en  = 1'b0;
    logic    exp_wr_sel = 1'b0;

    pingpong_bank_ctrl dut (
        .CLK(CLK), .RST(RST), .sym_start(sym_start), .sym_len(sym_len),
        .mod_valid(mod_valid), .mod_ready(mod_ready), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_bank(wr_bank), .fft_ready(fft_ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_bank(rd_bank),
        .fft_start(fft_start), .fft_valid(fft_valid), .fft_last(fft_last),
        .bank_full(bank_full), .cfg_err(cfg_err), .ovf_err(ovf_err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Read-side scoreboard monitor, sampling on the falling edge
    logic    pend_v = 1'b0;
    logic    pend_l = 1'b0;
    logic    prev_rd = 1'b0;
    rd_exp_t e;
    always @(negedge CLK) begin
        if (!mon_en) begin
            pend_v  = 1'b0;
            prev_rd = 1'b0;
        end else begin
            check("fft_valid", fft_valid, pend_v);
            if (pend_v) check("fft_last", fft_last, pend_l);
            pend_v = 1'b0;
            if (rd_en) begin
                if (sb.size() == 0) begin
                    check("rd_unexpected", rd_en, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check("rd_bank", rd_bank, e.bank);
                    check("rd_addr", rd_addr, e.addr);
                    check("fft_start", fft_start, e.start);
                    if (fft_start) check("rd_gap", prev_rd, 1'b0);
                    pend_v = 1'b1;
                    pend_l = e.last;
                end
            end
            prev_rd = rd_en;
            if (ovf_err) ovf_cnt++;
        end
    end

    task automatic do_reset();
        mon_en    = 1'b0;
        RST       = 1'b0;
        sym_start = 1'b0;
        mod_valid = 1'b0;
        step();
        check("rst_mod_ready", mod_ready, 1'b0);
        check("rst_rd_en", rd_en, 1'b0);
        check("rst_bank_full", bank_full, 2'b00);
        check("rst_fft_valid", fft_valid, 1'b0);
        check("rst_fft_last", fft_last, 1'b0);
        check("rst_errs", {cfg_err, ovf_err}, 2'b00);
        check("rst_wr_addr", wr_addr, 11'd0);
        RST = 1'b1;
        sb.delete();
        exp_wr_sel = 1'b0;
        step();
        mon_en = 1'b1;
    endtask

    task automatic start_sym(input int len);
        sym_start = 1'b1;
        sym_len   = 11'(len);
        step();
        sym_start = 1'b0;
    endtask

    // Waits (bounded) for mod_ready, then feeds len samples; optional busy sym_start at cfg_at
    task automatic feed(input int len, input int cfg_at);
        int guard = 0;
        #1;
        while (mod_ready !== 1'b1 && guard < 5000) begin
            step();
            #1;
            guard++;
        end
        check("ready_wait", mod_ready, 1'b1);
        for (int i = 0; i < len; i++) begin
            mod_valid = 1'b1;
            if (i == cfg_at) begin
                sym_start = 1'b1;
                sym_len   = 11'd7;
            end
            #1;
            check("wr_en", wr_en, 1'b1);
            check("wr_addr", wr_addr, i);
            check("wr_bank", wr_bank, exp_wr_sel);
            sb.push_back(rd_exp_t'{bank: exp_wr_sel, addr: 11'(i), start: (i == 0), last: (i == len - 1)});
            step();
            if (i == cfg_at) begin
                sym_start = 1'b0;
                check("cfg_busy", cfg_err, 1'b1);
            end
        end
        mod_valid  = 1'b0;
        exp_wr_sel = ~exp_wr_sel;
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 5000) begin
            step();
            guard++;
        end
        step();
        step();
        check("sb_empty", sb.size(), 0);
    endtask

    initial begin
        int base;
        int guard;

        // Basic len=12 symbol with exact drain timing
        do_reset();
        fft_ready = 1'b1;
        start_sym(12);
        feed(12, -1);
        #1;
        check("t1_bank_full", bank_full, 2'b01);
        check("t1_rd_early", rd_en, 1'b0);
        step();
        check("t1_rd_en", rd_en, 1'b1);
        check("t1_fft_start", fft_start, 1'b1);
        check("t1_rd_addr0", rd_addr, 11'd0);
        for (int k = 0; k < 12; k++) step();
        check("t1_fft_last", fft_last, 1'b1);
        wait_drain();
        start_sym(3);
        feed(3, -1);
        wait_drain();

        // Three back-to-back full-depth symbols with the FFT initially stalled
        do_reset();
        fft_ready = 1'b0;
        base = ovf_cnt;
        start_sym(1200);
        feed(1200, -1);
        start_sym(1200);
        feed(1200, -1);
        start_sym(1200);
        step();
        step();
        #1;
        check("t2_wait_ready", mod_ready, 1'b0);
        check("t2_both_full", bank_full, 2'b11);
        fft_ready = 1'b1;
        feed(1200, -1);
        wait_drain();
        check("t2_no_ovf", ovf_cnt, base);

        // Illegal lengths
        sym_start = 1'b1;
        sym_len   = 11'd0;
        step();
        sym_start = 1'b0;
        check("t3_cfg_len0", cfg_err, 1'b1);
        check("t3_ready0", mod_ready, 1'b0);
        step();
        check("t3_cfg_clear", cfg_err, 1'b0);
        sym_start = 1'b1;
        sym_len   = 11'd1201;
        step();
        sym_start = 1'b0;
        check("t3_cfg_len1201", cfg_err, 1'b1);
        check("t3_ready1201", mod_ready, 1'b0);
        step();
        check("t3_still_idle", mod_ready, 1'b0);
        check("t3_banks", bank_full, 2'b00);

        // Overflow in idle, then sym_start mid-fill
        mod_valid = 1'b1;
        #1;
        check("t4_wr_dropped", wr_en, 1'b0);
        step();
        mod_valid = 1'b0;
        #1;
        check("t4_ovf", ovf_err, 1'b1);
        step();
        check("t4_ovf_clear", ovf_err, 1'b0);
        start_sym(5);
        feed(5, 2);
        wait_drain();

        // Continuous len=1 symbols
        do_reset();
        fft_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            start_sym(1);
            feed(1, -1);
        end
        wait_drain();

        // Reset in the middle of a drain
        do_reset();
        start_sym(1200);
        feed(1200, -1);
        guard = 0;
        while (rd_addr !== 11'd500 && guard < 3000) begin
            step();
            guard++;
        end
        check("t6_addr500", rd_addr, 11'd500);
        mon_en = 1'b0;
        RST    = 1'b0;
        step();
        check("t6_rd_en", rd_en, 1'b0);
        check("t6_bank_full", bank_full, 2'b00);
        check("t6_fft_valid", fft_valid, 1'b0);
        check("t6_mod_ready", mod_ready, 1'b0);
        RST = 1'b1;
        sb.delete();
        exp_wr_sel = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t6_no_last", {fft_last, rd_en}, 2'b00);
        end
        mon_en = 1'b1;
        start_sym(4);
        feed(4, -1);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
